sd_spi_card_responder: RTL and testbench
========================================

Name: sd_spi_card_responder

Overview:
- Card-side SPI-mode SD responder; the counterpart of the host SPI command initiator on the card_MOSI/card_MISO/card_CS lines.
- Receives 48-bit command frames and returns R1, R3 or R7 responses after a programmable NCR gap.
- Tracks a minimal init state: idle, ACMD41 polling, ready.
- Used as a synthesizable card model in benches and for loopback bring-up on FPGA.

Parameters:
- NCR_BYTES, 1, number of 0xFF bytes driven before the response token (legal 1..8).
- INIT_POLLS, 2, number of ACMD41 commands answered with 0x01 before answering 0x00.
- OCR_VALUE, 32'hC0FF8000, OCR returned by CMD58 once ready; bit 31 is forced to 0 while in idle.

Ports:
- clk  input  1  SPI bit clock (same sd_clk that clocks the host block); synchronous reset, active-low.
- res_n  input  1  synchronous active-low reset.
- card_CS  input  1  chip select, active low.
- card_MOSI  input  1  command bits from host, MSB first.
- card_MISO  output  1  response bits to host, MSB first; idles at 1.
- cmd_valid  output  1  one-cycle pulse when a complete frame is accepted.
- cmd_index  output  6  index of the last accepted command.
- cmd_arg  output  32  argument of the last accepted command.
- in_idle  output  1  card idle flag (R1 bit 0).

Behaviour:
- Reset (res_n=0 at a rising clk):
  - Outputs: card_MISO=1, cmd_valid=0, cmd_index=0, cmd_arg=0, in_idle=1.
  - Internal: poll counter=0, app_cmd flag=0, state=IDLE.
- Timing: MOSI is sampled on rising clk; MISO is a registered output updated on rising clk.
- Any cycle with card_CS=1: return to IDLE with MISO=1, discard any partial frame or response. Flags are kept.
- IDLE:
  - card_CS=0 and card_MOSI=0: the start bit is detected; go to RX with bit count 1.
  - card_MOSI=1: stay in IDLE (host filler 0xFF).
- RX:
  - Shift 47 further bits (48 total).
  - Frame check: bit46 (transmission bit) must be 1 and bit0 (end bit) must be 1. If either is wrong, drop the frame silently and go to IDLE.
  - Valid frame: pulse cmd_valid in the cycle after the last bit, latch cmd_index/cmd_arg, then go to NCR.
- NCR: drive MISO=1 for NCR_BYTES*8 cycles, then go to TX.
- TX: shift the response MSB first, then go to IDLE with MISO=1. Response by command:
  - CMD0: R1=0x01. Sets in_idle=1, poll counter=0.
  - CMD8: R7 = R1(in_idle) followed by 32 bits {20'h0, arg[11:8], arg[7:0]} (voltage and check-pattern echo). 40 bits total.
  - CMD55: R1={7'b0,in_idle}. Sets app_cmd=1.
  - CMD41 with app_cmd=1:
    - poll counter < INIT_POLLS: R1=0x01 and increment the counter.
    - otherwise: in_idle=0, R1=0x00.
  - CMD58: R3 = R1 followed by OCR (OCR_VALUE with bit31 cleared if in_idle). 40 bits.
  - Any other command: R1={5'b0,1'b1,1'b0,in_idle} (illegal command).
- app_cmd is cleared after any command other than CMD55.
- Flag and counter updates take effect at the cmd_valid cycle.
- A new start bit during NCR or TX is ignored; frames are not pipelined.

Optional Feature:
- Macro: SD_SPI_CARD_CRC_CHECK_EN.
- Defined:
  - A serial CRC7 is computed over bits 47..8 and compared with bits 7..1.
  - On mismatch, cmd_valid still pulses, but no state changes are applied and the response is R1={4'b0,1'b1,2'b0,in_idle} (COM CRC error).
- Undefined: the CRC field is ignored and no CRC logic is instantiated.

Decomposition:
- Package sd_card_pkg holds:
  - Command index constants: CMD0, CMD8, CMD41, CMD55, CMD58.
  - R1 bit position constants: IDLE=0, ILLEGAL=2, CRC_ERR=3.
  - SD_FRAME_BITS=48.
  - The state enum: IDLE, RX, NCR, TX.
- Sub-module sd_crc7: serial CRC7 (x^7+x^3+1) with clear/enable inputs, instantiated only under the macro.

Test Plan:
- CMD0 frame 0x40_00000000_95 with NCR_BYTES=1 → cmd_valid pulse with cmd_index=0. MISO stays 1 for 8 cycles, then 0x01 appears, then MISO=1.
- CMD8 frame 0x48_000001AA_87 → R7 40 bits = 0x01_000001AA.
- CMD55+ACMD41 pair sent three times with INIT_POLLS=2:
  - Responses 0x01, 0x01, 0x00; in_idle falls after the third ACMD41.
  - CMD58 then returns 0x00_C0FF8000. Before init, CMD58 returns 0x01_40FF8000.
- CMD5 frame 0x45_00000000_01 → R1=0x05.
- card_CS deasserted after 20 bits of CMD0, then reasserted with a full CMD0 → no response from the aborted frame; the full frame is answered 0x01. Repeat the abort during TX → MISO=1 immediately.
- With SD_SPI_CARD_CRC_CHECK_EN defined:
  - CMD0 sent with CRC byte 0x97 → R1=0x09 and the poll counter is unchanged.
  - The same frame with 0x95 → 0x01.
- res_n pulsed low mid-TX → card_MISO=1 and in_idle=1 on the next rising clk.

Source files
------------

// File: rtl/sd_card_pkg.sv
// Shared constants and types for the SPI-mode SD card responder.
package sd_card_pkg;

    localparam int SD_FRAME_BITS = 48;
    localparam int RESP_BITS     = 40;

    localparam logic [5:0] CMD0  = 6'd0;
    localparam logic [5:0] CMD8  = 6'd8;
    localparam logic [5:0] CMD41 = 6'd41;
    localparam logic [5:0] CMD55 = 6'd55;
    localparam logic [5:0] CMD58 = 6'd58;

    localparam int R1_IDLE    = 0;
    localparam int R1_ILLEGAL = 2;
    localparam int R1_CRC_ERR = 3;

    typedef enum logic [1:0] {IDLE, RX, NCR, TX} state_e;

    // Response left-aligned in bits, len = number of bits to shift out (8 or 40)
    typedef struct packed {
        logic [RESP_BITS-1:0] bits;
        logic [5:0]           len;
    } resp_t;

endpackage

// File: rtl/sd_crc7.sv
// Serial CRC7 (x^7 + x^3 + 1), one message bit per enabled cycle, MSB first.
// Only compiled when SD_SPI_CARD_CRC_CHECK_EN is defined.
`ifdef SD_SPI_CARD_CRC_CHECK_EN
module sd_crc7 (
    input  logic       clk_i,
    input  logic       res_n_i,
    input  logic       clr_i,
    input  logic       en_i,
    input  logic       din_i,
    output logic [6:0] crc_o
);
    logic [6:0] crc_q, crc_d, base;
    logic       fb;

    // clr and en together restart the CRC with the current bit as the first one
    always_comb begin
        base  = clr_i ? 7'h00 : crc_q;
        fb    = base[6] ^ din_i;
        crc_d = base;
        if (en_i) crc_d = {base[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
    end

    always_ff @(posedge clk_i) begin
        if (!res_n_i) crc_q <= '0;
        else          crc_q <= crc_d;
    end

    assign crc_o = crc_q;
endmodule
`endif

// File: rtl/sd_spi_card_responder.sv
// SPI-mode SD card responder: accepts 48-bit command frames, answers R1/R3/R7 after NCR.
// Define SD_SPI_CARD_CRC_CHECK_EN to check the CRC7 field and answer COM CRC errors.
module sd_spi_card_responder
    import sd_card_pkg::*;
#(
    parameter int unsigned NCR_BYTES  = 1,
    parameter int unsigned INIT_POLLS = 2,
    parameter logic [31:0] OCR_VALUE  = 32'hC0FF8000
) (
    input  logic        clk,
    input  logic        res_n,
    input  logic        card_CS,
    input  logic        card_MOSI,
    output logic        card_MISO,
    output logic        cmd_valid,
    output logic [5:0]  cmd_index,
    output logic [31:0] cmd_arg,
    output logic        in_idle
);
    localparam logic [6:0] LAST_BIT = 7'(SD_FRAME_BITS - 1);
    localparam logic [6:0] NCR_LAST = 7'(NCR_BYTES * 8 - 1);

    state_e      state_q, state_d;
    logic [6:0]  cnt_q, cnt_d;
    logic [45:0] shreg_q, shreg_d;
    logic [39:0] resp_q, resp_d;
    logic [5:0]  rlen_q, rlen_d;
    logic        miso_q, miso_d;
    logic        valid_q, valid_d;
    logic [5:0]  idx_q, idx_d;
    logic [31:0] arg_q, arg_d;
    logic        idle_q, idle_d;
    logic        app_q, app_d;
    logic [7:0]  poll_q, poll_d;

    // While the end bit is on MOSI, shreg holds frame bits 46..1
    logic [5:0]  f_idx;
    logic [31:0] f_arg;
    logic        f_ok, last_bit, ncr_done, tx_done, crc_ok;

    assign f_idx    = shreg_q[44:39];
    assign f_arg    = shreg_q[38:7];
    assign f_ok     = shreg_q[45] & card_MOSI;
    assign last_bit = (state_q == RX)  && (cnt_q == LAST_BIT);
    assign ncr_done = (state_q == NCR) && (cnt_q == NCR_LAST);
    assign tx_done  = (state_q == TX)  && (cnt_q == {1'b0, rlen_q});

`ifdef SD_SPI_CARD_CRC_CHECK_EN
    logic [6:0] crc_w;
    logic       crc_clr, crc_en;

    assign crc_clr = (state_q == IDLE) && !card_CS && !card_MOSI;
    assign crc_en  = crc_clr || ((state_q == RX) && !card_CS && (cnt_q < 7'd40));

    sd_crc7 u_crc7 (
        .clk_i   (clk),
        .res_n_i (res_n),
        .clr_i   (crc_clr),
        .en_i    (crc_en),
        .din_i   (card_MOSI),
        .crc_o   (crc_w)
    );
    assign crc_ok = (crc_w == shreg_q[6:0]);
`else
    assign crc_ok = 1'b1;
`endif

    // Response and flag updates for the frame completing this cycle
    resp_t       rsp;
    logic [7:0]  r1;
    logic [31:0] ocr;
    logic        n_idle, n_app;
    logic [7:0]  n_poll;

    always_comb begin
        r1       = 8'(1 << R1_ILLEGAL) | {7'b0, idle_q};
        ocr      = OCR_VALUE;
        if (idle_q) ocr[31] = 1'b0;
        rsp.bits = '1;
        rsp.len  = 6'd8;
        n_idle   = idle_q;
        n_app    = 1'b0;
        n_poll   = poll_q;
        case (f_idx)
            CMD0: begin
                r1     = 8'h01;
                n_idle = 1'b1;
                n_poll = '0;
            end
            CMD8: begin
                r1             = {7'b0, idle_q};
                rsp.len        = 6'd40;
                rsp.bits[31:0] = {20'h0, f_arg[11:0]};
            end
            CMD55: begin
                r1    = {7'b0, idle_q};
                n_app = 1'b1;
            end
            CMD41: if (app_q) begin
                if (32'(poll_q) < INIT_POLLS) begin
                    r1     = 8'h01;
                    n_poll = poll_q + 8'd1;
                end else begin
                    r1     = 8'h00;
                    n_idle = 1'b0;
                end
            end
            CMD58: begin
                r1             = {7'b0, idle_q};
                rsp.len        = 6'd40;
                rsp.bits[31:0] = ocr;
            end
            default: ;
        endcase
        // A corrupted command leaves every flag untouched
        if (!crc_ok) begin
            r1      = 8'(1 << R1_CRC_ERR) | {7'b0, idle_q};
            rsp.len = 6'd8;
            n_idle  = idle_q;
            n_app   = app_q;
            n_poll  = poll_q;
        end
        rsp.bits[39:32] = r1;
    end

    always_ff @(posedge clk) begin
        if (!res_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            shreg_q <= '0;
            resp_q  <= '1;
            rlen_q  <= '0;
            miso_q  <= 1'b1;
            valid_q <= 1'b0;
            idx_q   <= '0;
            arg_q   <= '0;
            idle_q  <= 1'b1;
            app_q   <= 1'b0;
            poll_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            shreg_q <= shreg_d;
            resp_q  <= resp_d;
            rlen_q  <= rlen_d;
            miso_q  <= miso_d;
            valid_q <= valid_d;
            idx_q   <= idx_d;
            arg_q   <= arg_d;
            idle_q  <= idle_d;
            app_q   <= app_d;
            poll_q  <= poll_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (card_CS) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:    if (!card_MOSI) state_d = RX;
                RX:      if (last_bit)   state_d = f_ok ? NCR : IDLE;
                NCR:     if (ncr_done)   state_d = TX;
                TX:      if (tx_done)    state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        cnt_d   = cnt_q;
        shreg_d = shreg_q;
        resp_d  = resp_q;
        rlen_d  = rlen_q;
        miso_d  = 1'b1;
        valid_d = 1'b0;
        idx_d   = idx_q;
        arg_d   = arg_q;
        idle_d  = idle_q;
        app_d   = app_q;
        poll_d  = poll_q;
        if (card_CS) begin
            cnt_d = '0;
        end else begin
            case (state_q)
                IDLE: if (!card_MOSI) begin
                    cnt_d   = 7'd1;
                    shreg_d = '0;
                end
                RX: begin
                    shreg_d = {shreg_q[44:0], card_MOSI};
                    cnt_d   = cnt_q + 7'd1;
                    if (last_bit) begin
                        cnt_d = '0;
                        if (f_ok) begin
                            valid_d = 1'b1;
                            idx_d   = f_idx;
                            arg_d   = f_arg;
                            resp_d  = rsp.bits;
                            rlen_d  = rsp.len;
                            idle_d  = n_idle;
                            app_d   = n_app;
                            poll_d  = n_poll;
                        end
                    end
                end
                NCR: begin
                    cnt_d = cnt_q + 7'd1;
                    if (ncr_done) begin
                        cnt_d  = 7'd1;
                        miso_d = resp_q[39];
                        resp_d = {resp_q[38:0], 1'b1};
                    end
                end
                TX: begin
                    if (tx_done) begin
                        cnt_d = '0;
                    end else begin
                        cnt_d  = cnt_q + 7'd1;
                        miso_d = resp_q[39];
                        resp_d = {resp_q[38:0], 1'b1};
                    end
                end
                default: ;
            endcase
        end
    end

    assign card_MISO = miso_q;
    assign cmd_valid = valid_q;
    assign cmd_index = idx_q;
    assign cmd_arg   = arg_q;
    assign in_idle   = idle_q;

endmodule

// File: tb/tb_sd_spi_card_responder.sv
// Randomized bench for sd_spi_card_responder against a command-level card model.
module tb_sd_spi_card_responder;
    localparam int          NCR_BYTES  = 1;
    localparam int          INIT_POLLS = 2;
    localparam logic [31:0] OCR_VALUE  = 32'hC0FF8000;

    logic        clk = 1'b0;
    logic        res_n, card_CS, card_MOSI;
    logic        card_MISO, cmd_valid, in_idle;
    logic [5:0]  cmd_index;
    logic [31:0] cmd_arg;

    int nchk = 0;
    int nerr = 0;
    bit m_idle, m_app;
    int m_poll;

    sd_spi_card_responder #(
        .NCR_BYTES  (NCR_BYTES),
        .INIT_POLLS (INIT_POLLS),
        .OCR_VALUE  (OCR_VALUE)
    ) dut (
        .clk       (clk),
        .res_n     (res_n),
        .card_CS   (card_CS),
        .card_MOSI (card_MOSI),
        .card_MISO (card_MISO),
        .cmd_valid (cmd_valid),
        .cmd_index (cmd_index),
        .cmd_arg   (cmd_arg),
        .in_idle   (in_idle)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        nchk++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // CRC7 by polynomial long division of msg * x^7 by x^7 + x^3 + 1
    function automatic logic [6:0] crc7_ref(input logic [39:0] msg);
        logic [46:0] r;
        r = {msg, 7'b0};
        for (int i = 46; i >= 7; i--)
            if (r[i]) r[i -: 8] = r[i -: 8] ^ 8'h89;
        return r[6:0];
    endfunction

    function automatic logic [47:0] mk_frame(input logic [5:0] idx, input logic [31:0] arg);
        return {2'b01, idx, arg, crc7_ref({2'b01, idx, arg}), 1'b1};
    endfunction

    // Card behaviour per command; rsp is right-aligned, len bits long
    task automatic model_cmd(input logic [5:0] idx, input logic [31:0] arg, input bit crc_ok,
                             output logic [39:0] rsp, output int len);
        logic [31:0] ocr;
        logic [39:0] illegal;
        len     = 8;
        illegal = 40'(32'h4 + 32'(m_idle));
        if (!crc_ok) begin
            rsp = 40'(32'h8 + 32'(m_idle));
            return;
        end
        case (idx)
            6'd0:  begin m_idle = 1'b1; m_poll = 0; rsp = 40'h01; end
            6'd8:  begin rsp = {7'b0, m_idle, 20'h0, arg[11:0]}; len = 40; end
            6'd55: rsp = 40'(m_idle);
            6'd41: begin
                if (!m_app) rsp = illegal;
                else if (m_poll < INIT_POLLS) begin m_poll++; rsp = 40'h01; end
                else begin m_idle = 1'b0; rsp = 40'h00; end
            end
            6'd58: begin
                ocr = OCR_VALUE;
                if (m_idle) ocr[31] = 1'b0;
                rsp = {7'b0, m_idle, ocr};
                len = 40;
            end
            default: rsp = illegal;
        endcase
        m_app = (idx == 6'd55);
    endtask

    task automatic tick(input logic b);
        @(negedge clk);
        card_MOSI = b;
    endtask

    // mode 0: full exchange; 1: CS abort at response bit `at`; 2: reset at response bit `at`
    task automatic run_cmd(input logic [47:0] fr, input string tag, input int mode = 0, input int at = 0);
        logic [39:0] exp_rsp, got;
        int          len, ones;
        bit          crc_ok, noise;
        crc_ok = 1'b1;
`ifdef SD_SPI_CARD_CRC_CHECK_EN
        crc_ok = (crc7_ref(fr[47:8]) == fr[7:1]);
`endif
        for (int i = 47; i >= 0; i--) tick(fr[i]);
        @(negedge clk);
        card_MOSI = 1'b1;
        if (!(fr[46] && fr[0])) begin
            chk({tag, " drop vld"}, cmd_valid, 0);
            noise = 1'b0;
            for (int i = 0; i < NCR_BYTES * 8 + 48; i++) begin
                if (!card_MISO || cmd_valid) noise = 1'b1;
                @(negedge clk);
            end
            chk({tag, " drop quiet"}, noise, 0);
            return;
        end
        chk({tag, " vld"}, cmd_valid, 1);
        chk({tag, " idx"}, cmd_index, fr[45:40]);
        chk({tag, " arg"}, cmd_arg, fr[39:8]);
        model_cmd(fr[45:40], fr[39:8], crc_ok, exp_rsp, len);
        ones = 0;
        while (card_MISO && ones < 100) begin
            @(negedge clk);
            ones++;
            if (ones == 1) chk({tag, " pulse"}, cmd_valid, 0);
        end
        chk({tag, " ncr"}, ones, NCR_BYTES * 8);
        got = '0;
        for (int i = 0; i < len; i++) begin
            if (mode != 0 && i == at) begin
                if (mode == 1) card_CS = 1'b1;
                else           res_n   = 1'b0;
                @(negedge clk);
                chk({tag, " abort miso"}, card_MISO, 1);
                if (mode == 2) begin
                    chk({tag, " rst idle"}, in_idle, 1);
                    chk({tag, " rst vld"}, cmd_valid, 0);
                    m_idle = 1'b1; m_app = 1'b0; m_poll = 0;
                    res_n  = 1'b1;
                end
                repeat (2) @(negedge clk);
                chk({tag, " after abort"}, card_MISO, 1);
                card_CS = 1'b0;
                return;
            end
            got = {got[38:0], card_MISO};
            @(negedge clk);
        end
        chk({tag, " rsp"}, got, exp_rsp);
        chk({tag, " tail"}, card_MISO, 1);
        chk({tag, " idle"}, in_idle, m_idle);
    endtask

    task automatic init_seq(input string tag);
        for (int k = 0; k < INIT_POLLS + 1; k++) begin
            run_cmd(mk_frame(6'd55, 32'h0), {tag, " cmd55"});
            run_cmd(mk_frame(6'd41, 32'h40000000), {tag, " acmd41"});
        end
    endtask

    logic [47:0] f_cmd0, f_cmd8, f_cmd5, fr;
    logic [5:0]  ridx;
    bit          noise;
    int          pick;

    initial begin
        f_cmd0 = 48'h40_00000000_95;
        f_cmd8 = 48'h48_000001AA_87;
        f_cmd5 = 48'h45_00000000_01;
        m_idle = 1'b1; m_app = 1'b0; m_poll = 0;
        res_n = 1'b0; card_CS = 1'b1; card_MOSI = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst miso", card_MISO, 1);
        chk("rst vld", cmd_valid, 0);
        chk("rst idx", cmd_index, 0);
        chk("rst arg", cmd_arg, 0);
        chk("rst idle", in_idle, 1);
        res_n = 1'b1;
        @(negedge clk);
        card_CS = 1'b0;
        repeat (4) tick(1'b1);

        run_cmd(f_cmd0, "cmd0");
        run_cmd(f_cmd8, "cmd8");
        run_cmd(mk_frame(6'd58, 32'h0), "cmd58 pre");
        run_cmd(f_cmd5, "cmd5");
        init_seq("init");
        chk("ready", in_idle, 0);
        run_cmd(mk_frame(6'd58, 32'h0), "cmd58 post");

        // abort a CMD0 after 20 bits; nothing may come back
        for (int i = 47; i >= 28; i--) tick(f_cmd0[i]);
        @(negedge clk);
        card_CS = 1'b1; card_MOSI = 1'b1;
        repeat (2) @(negedge clk);
        card_CS = 1'b0;
        noise = 1'b0;
        repeat (70) begin
            if (!card_MISO || cmd_valid) noise = 1'b1;
            @(negedge clk);
        end
        chk("abort rx quiet", noise, 0);
        run_cmd(f_cmd0, "cmd0 after abort");
        run_cmd(f_cmd8, "cmd8 tx abort", 1, 12);

`ifdef SD_SPI_CARD_CRC_CHECK_EN
        run_cmd(mk_frame(6'd55, 32'h0), "crc cmd55");
        run_cmd(mk_frame(6'd41, 32'h0), "crc acmd41");
        fr = f_cmd0;
        fr[7:0] = 8'h97;
        run_cmd(fr, "cmd0 bad crc");
        run_cmd(mk_frame(6'd55, 32'h0), "crc cmd55 b");
        run_cmd(mk_frame(6'd41, 32'h0), "crc acmd41 b");
        run_cmd(f_cmd0, "cmd0 good crc");
`endif

        for (int n = 0; n < 40; n++) begin
            pick = int'($urandom_range(0, 9));
            case (pick)
                0:       ridx = 6'd0;
                1, 2, 3: ridx = 6'd55;
                4:       ridx = 6'd41;
                5:       ridx = 6'd8;
                6:       ridx = 6'd58;
                default: ridx = 6'($urandom_range(0, 63));
            endcase
            fr = mk_frame(ridx, $urandom);
            if ($urandom_range(0, 7) == 0) begin
                if ($urandom_range(0, 1) == 0) fr[46] = 1'b0;
                else                           fr[0]  = 1'b0;
            end
            if ($urandom_range(0, 5) == 0) fr[1 + $urandom_range(0, 6)] ^= 1'b1;
            run_cmd(fr, $sformatf("rnd%0d", n));
            if (ridx == 6'd55 && pick != 0) run_cmd(mk_frame(6'd41, $urandom), $sformatf("rnd%0d a41", n));
            repeat ($urandom_range(0, 4)) tick(1'b1);
            if ($urandom_range(0, 3) == 0) begin
                card_CS = 1'b1;
                repeat (2) tick(1'b1);
                card_CS = 1'b0;
            end
        end

        run_cmd(f_cmd0, "pre rst cmd0");
        init_seq("pre rst");
        run_cmd(mk_frame(6'd58, 32'h0), "cmd58 rst", 2, 20);
        run_cmd(f_cmd0, "cmd0 after rst");
        run_cmd(mk_frame(6'd58, 32'h0), "cmd58 after rst");

        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end
endmodule
